// File: rtl/mul32u_sched_pkg.sv
// mul32u_sched shared types and widths.
// States, operand/result widths and the latency counter width.
package mul32u_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  function automatic int cnt_w(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mul32u_sched_if.sv
// Request/response and multiplier bundle for mul32u_sched.
// slave = scheduler side, master = clients plus multiplier side.
interface mul32u_sched_if
  import mul32u_sched_pkg::*;
#(
  parameter int N = 4
) ();

  logic [N-1:0]        req_vld;
  logic [OP_W*N-1:0]   req_op1;
  logic [OP_W*N-1:0]   req_op2;
  logic [N-1:0]        req_rdy;
  logic [N-1:0]        rsp_vld;
  logic [RES_W-1:0]    rsp_res;
  logic                mul_start;
  logic [OP_W-1:0]     mul_op1;
  logic [OP_W-1:0]     mul_op2;
  logic [RES_W-1:0]    mul_res;
  logic                busy;

  modport slave (
    input  req_vld, req_op1, req_op2, mul_res,
    output req_rdy, rsp_vld, rsp_res,
    output mul_start, mul_op1, mul_op2, busy
  );

  modport master (
    output req_vld, req_op1, req_op2, mul_res,
    input  req_rdy, rsp_vld, rsp_res,
    input  mul_start, mul_op1, mul_op2, busy
  );

endinterface

// File: rtl/mul32u_sched_rr_arb.sv
// Combinational round-robin arbiter.
// Lowest requesting index at or after ptr wins, wrapping.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  // scan from ptr upward, first hit takes the grant
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mul32u_sched.sv
// Round-robin scheduler sharing one sequential 32x32 multiplier.
// Option MUL32U_SCHED_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mul32u_sched
  import mul32u_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int MUL_LAT = 33
) (
  input  logic           clk,
  input  logic           rst,
  mul32u_sched_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_w(MUL_LAT);
  localparam logic [CW-1:0] CMAX = CW'(MUL_LAT - 2);
`ifdef MUL32U_SCHED_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  state_t state, nxt;

  logic [IW-1:0]    ptr, gsel, gnt_q;
  logic [N-1:0]     gnt, rdy, rsp_v;
  logic [CW-1:0]    cnt;
  logic [OP_W-1:0]  sel1, sel2, op1_q, op2_q;
  logic [RES_W-1:0] rsp_r;
  logic             load_en, start, zero, zflag;

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .req (bus.req_vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gsel)
  );

  assign sel1 = bus.req_op1[int'(gsel)*OP_W +: OP_W];
  assign sel2 = bus.req_op2[int'(gsel)*OP_W +: OP_W];
  assign zero = BYP && (sel1 == '0 || sel2 == '0);

  assign bus.req_rdy   = rdy;
  assign bus.mul_start = start;
  assign bus.mul_op1   = op1_q;
  assign bus.mul_op2   = op2_q;
  assign bus.rsp_vld   = rsp_v;
  assign bus.rsp_res   = rsp_r;
  assign bus.busy      = (state != IDLE);

  // next state, accept and start strobe
  always_comb begin
    nxt     = state;
    rdy     = '0;
    start   = 1'b0;
    load_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst && bus.req_vld != '0) begin
          rdy     = gnt;
          load_en = 1'b1;
          nxt     = zero ? DONE : LOAD;
        end
      end
      LOAD: begin
        start = 1'b1;
        nxt   = RUN;
      end
      RUN: begin
        if (cnt == CMAX) nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state, operand latch, latency count and response register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt_q <= '0;
      zflag <= 1'b0;
      op1_q <= '0;
      op2_q <= '0;
      rsp_v <= '0;
      rsp_r <= '0;
    end else begin
      state <= nxt;
      rsp_v <= '0;
      if (load_en) begin
        op1_q <= sel1;
        op2_q <= sel2;
        gnt_q <= gsel;
        zflag <= zero;
      end
      if (state == LOAD)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + 1'b1;
      if (state == DONE) begin
        rsp_v[gnt_q] <= 1'b1;
        rsp_r <= zflag ? '0 : bus.mul_res;
        ptr   <= (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

endmodule
